// File: rtl/timer_counter.sv
// Memory-mapped countdown timer with CTRL / PRESET / COUNT registers.
// Counts down from PRESET while CTRL.EN is set, then raises an interrupt flag.
// The flag is exposed on IRQ when CTRL.IM is set.
`timescale 1ns/1ps

module timer_counter #(
    parameter logic [31:0] PRESET_RST = 32'h0000_0000,
    parameter logic [31:0] CTRL_MASK  = 32'h0000_000F
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [29:0] addr,
    input  logic        WE,
    input  logic [31:0] Din,
    output logic [31:0] Dout,
    output logic        IRQ
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CNT  = 2'd2,
        ST_INT  = 2'd3
    } state_t;

    // Register select codes (word offsets inside the timer window).
    localparam logic [1:0] SEL_CTRL   = 2'd0;
    localparam logic [1:0] SEL_PRESET = 2'd1;
    localparam logic [1:0] SEL_COUNT  = 2'd2;

    localparam logic [1:0] MODE_PERIODIC = 2'b01;

    state_t      state;
    logic [31:0] ctrl;
    logic [31:0] preset;
    logic [31:0] count;
    logic        irq_flag;

    // addr is already a word address, so byte bits [3:2] sit at addr[1:0].
    logic [1:0] sel;
    assign sel = addr[1:0];

    // Upper address bits are decoded upstream.
    logic unused_addr;
    assign unused_addr = ^addr[29:2];

    logic       en;
    logic [1:0] mode;
    logic       im;
    assign en   = ctrl[0];
    assign mode = ctrl[2:1];
    assign im   = ctrl[3];

    logic wr_ctrl;
    logic wr_preset;
    assign wr_ctrl   = WE && (sel == SEL_CTRL);
    assign wr_preset = WE && (sel == SEL_PRESET);

    // Countdown FSM together with the bus-writable registers and the interrupt flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            ctrl     <= '0;
            preset   <= PRESET_RST;
            count    <= '0;
            irq_flag <= 1'b0;
        end else begin
            // NOTE: all state here updates with <= so every branch sees pre-edge values;
            // later assignments in this block deliberately override earlier ones.

            // Periodic mode turns the flag into a one-cycle pulse.
            if (irq_flag && (mode == MODE_PERIODIC)) begin
                irq_flag <= 1'b0;
            end

            unique case (state)
                ST_IDLE: begin
                    if (en) begin
                        state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    count <= preset;
                    state <= ST_CNT;
                end
                ST_CNT: begin
                    if (!en) begin
                        state <= ST_IDLE;
                    end else if (count > 32'd1) begin
                        count <= count - 32'd1;
                    end else begin
                        count <= '0;
                        state <= ST_INT;
                    end
                end
                ST_INT: begin
                    irq_flag <= 1'b1;
                    // Any mode other than periodic is one-shot: drop EN by hardware.
                    if (mode != MODE_PERIODIC) begin
                        ctrl[0] <= 1'b0;
                    end
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase

            // CPU writes come last so they win over the hardware EN clear and flag set.
            if (wr_ctrl) begin
                ctrl <= Din & CTRL_MASK;
            end
            if (wr_preset) begin
                preset <= Din;
            end
            if (wr_ctrl || wr_preset) begin
                irq_flag <= 1'b0;
            end
        end
    end

    // Read mux: combinational from the register select.
    always_comb begin
        // NOTE: default assignment first so no path through the case leaves Dout unassigned (no latch).
        Dout = '0;
        case (sel)
            SEL_CTRL:   Dout = ctrl;
            SEL_PRESET: Dout = preset;
            SEL_COUNT:  Dout = count;
            default:    Dout = '0;
        endcase
    end

    assign IRQ = irq_flag & im;

endmodule

// File: tb/tb_timer_counter.sv
// Self-checking bench for timer_counter: a driver issues bus cycles and pushes the
// expected read data / IRQ level into a scoreboard queue; a monitor pops and compares.
// The reference model reasons in edge numbers (load edge, terminal edge, interrupt edge)
// rather than in FSM states.
`timescale 1ns/1ps

module tb_timer_counter;

    localparam logic [31:0] PRESET_RST = 32'h0000_0000;
    localparam logic [31:0] CTRL_MASK  = 32'h0000_000F;

    logic        clk = 1'b0;
    logic        reset;
    logic [29:0] addr;
    logic        WE;
    logic [31:0] Din;
    logic [31:0] Dout;
    logic        IRQ;

    timer_counter #(
        .PRESET_RST(PRESET_RST),
        .CTRL_MASK (CTRL_MASK)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .addr (addr),
        .WE   (WE),
        .Din  (Din),
        .Dout (Dout),
        .IRQ  (IRQ)
    );

    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [1:0]  sel;
        logic [31:0] dout;
        logic        irq;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   passed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    logic [31:0] m_ctrl, m_preset, m_count, l_p;
    bit          m_flag, m_running;
    longint      n_edge = 0;
    longint      load_at, int_at, l_edge;

    task automatic model_reset();
        m_ctrl    = '0;
        m_preset  = PRESET_RST;
        m_count   = '0;
        m_flag    = 0;
        m_running = 0;
        load_at   = -1;
        int_at    = -1;
        l_edge    = 0;
        l_p       = '0;
    endtask

    // Advance the model across one rising edge with the bus inputs applied at that edge.
    task automatic model_step(input logic w, input logic [1:0] s, input logic [31:0] d);
        logic [31:0] nxt_ctrl;
        bit          set_flag;
        longint      k, span;
        n_edge++;
        nxt_ctrl = m_ctrl;
        set_flag = 0;
        if (n_edge == int_at) begin
            int_at   = -1;
            set_flag = 1;
            if (m_ctrl[2:1] != 2'b01) nxt_ctrl[0] = 1'b0;
        end else if (n_edge == load_at) begin
            load_at   = -1;
            m_count   = m_preset;
            l_edge    = n_edge;
            l_p       = m_preset;
            m_running = 1;
        end else if (m_running) begin
            if (!m_ctrl[0]) begin
                m_running = 0;
            end else begin
                k    = n_edge - l_edge;
                span = (l_p == 0) ? 1 : longint'(l_p);
                if (k >= span) begin
                    m_count   = '0;
                    m_running = 0;
                    int_at    = n_edge + 1;
                end else begin
                    m_count = l_p - 32'(k);
                end
            end
        end else if (m_ctrl[0]) begin
            load_at = n_edge + 1;
        end
        if (w && s == 2'd0) nxt_ctrl = d & CTRL_MASK;
        if (w && s == 2'd1) m_preset = d;
        if (w && (s == 2'd0 || s == 2'd1)) m_flag = 0;
        else if (set_flag) m_flag = 1;
        else if (m_flag && m_ctrl[2:1] == 2'b01) m_flag = 0;
        m_ctrl = nxt_ctrl;
    endtask

    function automatic logic [31:0] model_read(input logic [1:0] s);
        case (s)
            2'd0:    return m_ctrl;
            2'd1:    return m_preset;
            2'd2:    return m_count;
            default: return 32'h0;
        endcase
    endfunction

    // ---------------- driver ----------------
    task automatic step(input bit r, input bit w, input logic [1:0] s, input logic [31:0] d);
        exp_t e;
        @(negedge clk);
        if (reset) model_step(WE, addr[1:0], Din);
        reset = r;
        if (!r) model_reset();
        WE   = w;
        addr = {28'($urandom()), s};
        Din  = d;
        e.sel  = s;
        e.dout = model_read(s);
        e.irq  = m_flag & m_ctrl[3];
        sb.push_back(e);
    endtask

    task automatic rd(input logic [1:0] s);
        step(1, 0, s, $urandom());
    endtask

    task automatic wr(input logic [1:0] s, input logic [31:0] d);
        step(1, 1, s, d);
    endtask

    // ---------------- monitor ----------------
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            while (sb.size() > 0) begin
                e = sb.pop_front();
                check($sformatf("dout_sel%0d", e.sel), Dout, e.dout);
                check("irq", 32'(IRQ), 32'(e.irq));
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int k;
        reset = 1'b0;
        WE    = 1'b0;
        addr  = '0;
        Din   = '0;
        model_reset();

        // Reset state, then abort a running count with reset.
        step(0, 0, 2'd0, 32'h0);
        step(0, 0, 2'd1, 32'h0);
        wr(2'd1, 32'd4);
        wr(2'd0, 32'h1);
        for (int i = 0; i < 4; i++) rd(2'd2);
        step(0, 0, 2'd2, 32'h0);
        step(0, 0, 2'd0, 32'h0);
        step(0, 0, 2'd1, 32'h0);
        for (int i = 0; i < 6; i++) rd(2'(i % 4));

        // One-shot with IM: IRQ held, CTRL reads 0x8, rewrite restarts.
        wr(2'd1, 32'd5);
        wr(2'd0, 32'h9);
        for (int i = 0; i < 11; i++) rd(2'd2);
        rd(2'd0);
        wr(2'd0, 32'h9);
        for (int i = 0; i < 4; i++) rd(2'd2);

        // Periodic with IM: one-cycle pulses every 6 cycles, EN stays set.
        wr(2'd0, 32'h0);
        wr(2'd1, 32'd3);
        wr(2'd0, 32'hB);
        for (int i = 0; i < 24; i++) rd((i % 3 == 0) ? 2'd0 : 2'd2);

        // Masked one-shot: flag sets silently, CTRL=0x9 clears it.
        wr(2'd0, 32'h0);
        wr(2'd1, 32'h10);
        wr(2'd0, 32'h1);
        for (int i = 0; i < 24; i++) rd(2'd2);
        wr(2'd0, 32'h9);
        for (int i = 0; i < 4; i++) rd(2'd0);

        // Stop mid-count at COUNT=7, COUNT is read-only, offset 3 reads zero.
        wr(2'd0, 32'h0);
        wr(2'd1, 32'd20);
        wr(2'd0, 32'h1);
        k = 0;
        while (!(m_running && m_count == 32'd7) && k < 100) begin
            rd(2'd2);
            k++;
        end
        check("t5_reach_count7", 32'(k < 100), 32'd1);
        wr(2'd0, 32'h0);
        for (int i = 0; i < 3; i++) rd(2'd2);
        wr(2'd2, 32'h55);
        rd(2'd2);
        wr(2'd3, 32'hFFFF_FFFF);
        rd(2'd3);

        // CPU CTRL write on the interrupt edge beats the hardware EN clear.
        wr(2'd1, 32'd2);
        wr(2'd0, 32'h1);
        k = 0;
        while (int_at != n_edge + 1 && k < 100) begin
            rd(2'd2);
            k++;
        end
        check("t6_reach_int", 32'(k < 100), 32'd1);
        wr(2'd0, 32'h9);
        for (int i = 0; i < 8; i++) rd((i == 0) ? 2'd0 : 2'd2);

        // Randomized traffic.
        for (int i = 0; i < 500; i++) begin
            int          r;
            logic [1:0]  s;
            logic [31:0] d;
            r = $urandom_range(0, 99);
            s = 2'($urandom_range(0, 3));
            if (r < 2) begin
                step(0, 0, s, $urandom());
            end else if (r < 22) begin
                if (s == 2'd1) d = $urandom_range(0, 9);
                else d = $urandom();
                wr(s, d);
            end else begin
                rd(s);
            end
        end
        rd(2'd0);

        @(negedge clk);
        #5;
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
